// File: rtl/dct_transpose_buffer_if.sv
// Row-in / column-out stream bundle for dct_transpose_buffer.
// master = upstream row source and downstream column sink; slave = the buffer.
interface dct_transpose_buffer_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] x0, x1, x2, x3, x4, x5, x6, x7;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_first;
  logic                  out_last;
  logic [DATA_WIDTH-1:0] y0, y1, y2, y3, y4, y5, y6, y7;

  modport master (
    output in_valid, x0, x1, x2, x3, x4, x5, x6, x7, out_ready,
    input  in_ready, out_valid, out_first, out_last, y0, y1, y2, y3, y4, y5, y6, y7
  );

  modport slave (
    input  in_valid, x0, x1, x2, x3, x4, x5, x6, x7, out_ready,
    output in_ready, out_valid, out_first, out_last, y0, y1, y2, y3, y4, y5, y6, y7
  );
endinterface

// File: rtl/dct_transpose_buffer.sv
// 8x8 row-to-column transpose buffer between the two 1-D DCT passes.
// Define TRANSPOSE_PINGPONG_EN for two banks so block N+1 fills while block N drains.
module dct_transpose_buffer #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic                  clk,
  input logic                  reset,
  dct_transpose_buffer_if.slave bus
);

`ifdef TRANSPOSE_PINGPONG_EN
  localparam int unsigned NumBanks = 2;
`else
  localparam int unsigned NumBanks = 1;
`endif

  logic [DATA_WIDTH-1:0] mem [NumBanks][8][8];
  logic [DATA_WIDTH-1:0] x_row [8];
  logic [DATA_WIDTH-1:0] y_col [8];

  logic [NumBanks-1:0] full_q, full_d;
  logic [2:0]          wr_row_q, rd_col_q;
  logic                wr_bank, rd_bank;
  logic                wr_fire, rd_fire, wr_done, rd_done;

  assign x_row[0] = bus.x0;
  assign x_row[1] = bus.x1;
  assign x_row[2] = bus.x2;
  assign x_row[3] = bus.x3;
  assign x_row[4] = bus.x4;
  assign x_row[5] = bus.x5;
  assign x_row[6] = bus.x6;
  assign x_row[7] = bus.x7;

  assign bus.in_ready  = !full_q[wr_bank];
  assign bus.out_valid = full_q[rd_bank];

  assign wr_fire = bus.in_valid && bus.in_ready;
  assign rd_fire = bus.out_valid && bus.out_ready;
  assign wr_done = wr_fire && (wr_row_q == 3'd7);
  assign rd_done = rd_fire && (rd_col_q == 3'd7);

`ifdef TRANSPOSE_PINGPONG_EN
  logic wr_bank_q, rd_bank_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
    end else begin
      if (wr_done) wr_bank_q <= !wr_bank_q;
      if (rd_done) rd_bank_q <= !rd_bank_q;
    end
  end

  assign wr_bank = wr_bank_q;
  assign rd_bank = rd_bank_q;
`else
  assign wr_bank = 1'b0;
  assign rd_bank = 1'b0;
`endif

  // Fill and drain always target different banks, so both edits apply.
  always_comb begin
    full_d = full_q;
    if (wr_done) full_d[wr_bank] = 1'b1;
    if (rd_done) full_d[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q   <= '0;
      wr_row_q <= 3'd0;
      rd_col_q <= 3'd0;
    end else begin
      full_q <= full_d;
      if (wr_fire) wr_row_q <= wr_row_q + 3'd1;
      if (rd_fire) rd_col_q <= rd_col_q + 3'd1;
    end
  end

  // Storage is deliberately not reset; full flags gate every read.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int c = 0; c < 8; c++) begin
        mem[wr_bank][wr_row_q][c] <= x_row[c];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      y_col[k] = '0;
    end
    bus.out_first = 1'b0;
    bus.out_last  = 1'b0;
    if (bus.out_valid) begin
      for (int k = 0; k < 8; k++) begin
        y_col[k] = mem[rd_bank][k][rd_col_q];
      end
      bus.out_first = (rd_col_q == 3'd0);
      bus.out_last  = (rd_col_q == 3'd7);
    end
  end

  assign bus.y0 = y_col[0];
  assign bus.y1 = y_col[1];
  assign bus.y2 = y_col[2];
  assign bus.y3 = y_col[3];
  assign bus.y4 = y_col[4];
  assign bus.y5 = y_col[5];
  assign bus.y6 = y_col[6];
  assign bus.y7 = y_col[7];

endmodule

// File: tb/tb_dct_transpose_buffer.sv
// Directed bench for dct_transpose_buffer; honours TRANSPOSE_PINGPONG_EN like the RTL.
module tb_dct_transpose_buffer;

`ifdef TRANSPOSE_PINGPONG_EN
  localparam logic PingPong = 1'b1;
  localparam int   Cap      = 16;
`else
  localparam logic PingPong = 1'b0;
  localparam int   Cap      = 8;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] xv [8];
  logic [31:0] yv [8];
  int          total;
  int          bad;

  dct_transpose_buffer_if #(.DATA_WIDTH(32)) bus ();

  dct_transpose_buffer #(.DATA_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.x0 = xv[0];
  assign bus.x1 = xv[1];
  assign bus.x2 = xv[2];
  assign bus.x3 = xv[3];
  assign bus.x4 = xv[4];
  assign bus.x5 = xv[5];
  assign bus.x6 = xv[6];
  assign bus.x7 = xv[7];
  assign yv[0]  = bus.y0;
  assign yv[1]  = bus.y1;
  assign yv[2]  = bus.y2;
  assign yv[3]  = bus.y3;
  assign yv[4]  = bus.y4;
  assign yv[5]  = bus.y5;
  assign yv[6]  = bus.y6;
  assign yv[7]  = bus.y7;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Row r of a block starting at base: xc = base + 8*r + c.
  task automatic set_row(input int base, input int r);
    for (int c = 0; c < 8; c++) xv[c] = 32'(base + 8 * r + c);
  endtask

  // Offers 8 rows on consecutive cycles; returns at the negedge after the last one.
  task automatic fill_block(input int base);
    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      set_row(base, r);
      bus.in_valid = 1'b1;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    set_row(0, 0);
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready);
    end
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid);
    end
    total++;
    if ({bus.out_first, bus.out_last} !== 2'b00) begin
      bad++; $display("FAIL rst_first_last: got %b want 00", {bus.out_first, bus.out_last});
    end
    for (int k = 0; k < 8; k++) begin
      total++;
      if (yv[k] !== 32'd0) begin
        bad++; $display("FAIL rst_y%0d: got %0d want 0", k, yv[k]);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_fill_drain();
    bus.out_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      set_row(0, r);
      bus.in_valid = 1'b1;
      #1;
      total++;
      if (bus.in_ready !== 1'b1) begin
        bad++; $display("FAIL fd_in_ready row%0d: got %b want 1", r, bus.in_ready);
      end
      total++;
      if (bus.out_valid !== 1'b0) begin
        bad++; $display("FAIL fd_early_valid row%0d: got %b want 0", r, bus.out_valid);
      end
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      total++;
      if (bus.out_valid !== 1'b1) begin
        bad++; $display("FAIL fd_valid col%0d: got %b want 1", c, bus.out_valid);
      end
      for (int k = 0; k < 8; k++) begin
        total++;
        if (yv[k] !== 32'(8 * k + c)) begin
          bad++; $display("FAIL fd_y col%0d k%0d: got %0d want %0d", c, k, yv[k], 8 * k + c);
        end
      end
      total++;
      if (bus.out_first !== (c == 0)) begin
        bad++; $display("FAIL fd_first col%0d: got %b want %b", c, bus.out_first, c == 0);
      end
      total++;
      if (bus.out_last !== (c == 7)) begin
        bad++; $display("FAIL fd_last col%0d: got %b want %b", c, bus.out_last, c == 7);
      end
      total++;
      if (bus.in_ready !== PingPong) begin
        bad++; $display("FAIL fd_drain_in_ready col%0d: got %b want %b", c, bus.in_ready, PingPong);
      end
    end
    @(negedge clk);
    #1;
    total++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      bad++; $display("FAIL fd_after: got %b want 01", {bus.out_valid, bus.in_ready});
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_back_pressure();
    bus.out_ready = 1'b0;
    fill_block(0);
    for (int s = 0; s < 10; s++) begin
      if (s > 0) @(negedge clk);
      #1;
      total++;
      if (bus.out_valid !== 1'b1) begin
        bad++; $display("FAIL bp_valid stall%0d: got %b want 1", s, bus.out_valid);
      end
      for (int k = 0; k < 8; k++) begin
        total++;
        if (yv[k] !== 32'(8 * k)) begin
          bad++; $display("FAIL bp_hold stall%0d k%0d: got %0d want %0d", s, k, yv[k], 8 * k);
        end
      end
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      #1;
      for (int k = 0; k < 8; k++) begin
        total++;
        if (yv[k] !== 32'(8 * k + c)) begin
          bad++; $display("FAIL bp_y col%0d k%0d: got %0d want %0d", c, k, yv[k], 8 * k + c);
        end
      end
      total++;
      if (bus.out_first !== (c == 0)) begin
        bad++; $display("FAIL bp_first col%0d: got %b want %b", c, bus.out_first, c == 0);
      end
    end
    @(negedge clk);
    #1;
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL bp_after: got %b want 0", bus.out_valid);
    end
    bus.out_ready = 1'b0;
  endtask

`ifdef TRANSPOSE_PINGPONG_EN
  task automatic test_pingpong();
    int base;
    int c;
    bus.out_ready = 1'b1;
    for (int j = 0; j < 24; j++) begin
      @(negedge clk);
      if (j < 16) begin
        set_row((j < 8) ? 0 : 100, j % 8);
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (j < 16) begin
        total++;
        if (bus.in_ready !== 1'b1) begin
          bad++; $display("FAIL pp_in_ready cyc%0d: got %b want 1", j, bus.in_ready);
        end
      end
      if (j >= 8) begin
        base = (j < 16) ? 0 : 100;
        c    = (j - 8) % 8;
        total++;
        if (bus.out_valid !== 1'b1) begin
          bad++; $display("FAIL pp_valid cyc%0d: got %b want 1", j, bus.out_valid);
        end
        for (int k = 0; k < 8; k++) begin
          total++;
          if (yv[k] !== 32'(base + 8 * k + c)) begin
            bad++;
            $display("FAIL pp_y cyc%0d k%0d: got %0d want %0d", j, k, yv[k], base + 8 * k + c);
          end
        end
        total++;
        if (bus.out_first !== (c == 0)) begin
          bad++; $display("FAIL pp_first cyc%0d: got %b want %b", j, bus.out_first, c == 0);
        end
      end else begin
        total++;
        if (bus.out_valid !== 1'b0) begin
          bad++; $display("FAIL pp_early_valid cyc%0d: got %b want 0", j, bus.out_valid);
        end
      end
    end
    @(negedge clk);
    #1;
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL pp_after: got %b want 0", bus.out_valid);
    end
    bus.out_ready = 1'b0;
  endtask
`endif

  task automatic test_full_stall();
    int accepted;
    accepted = 0;
    bus.out_ready = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      set_row(0, accepted);
      bus.in_valid = 1'b1;
      #1;
      if (bus.in_ready === 1'b1) accepted++;
    end
    total++;
    if (accepted !== Cap) begin
      bad++; $display("FAIL fs_accepted: got %0d want %0d", accepted, Cap);
    end
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++; $display("FAIL fs_in_ready: got %b want 0", bus.in_ready);
    end
    for (int i = 0; i < Cap; i++) begin
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      for (int k = 0; k < 8; k++) begin
        total++;
        if (yv[k] !== 32'(64 * (i / 8) + 8 * k + i % 8)) begin
          bad++;
          $display("FAIL fs_y col%0d k%0d: got %0d want %0d", i, k, yv[k],
                   64 * (i / 8) + 8 * k + i % 8);
        end
      end
    end
    @(negedge clk);
    #1;
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL fs_extra_row: got out_valid %b want 0", bus.out_valid);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    for (int r = 0; r < 5; r++) begin
      @(negedge clk);
      set_row(500, r);
      bus.in_valid = 1'b1;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    total++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      bad++; $display("FAIL rm_during: got %b want 01", {bus.out_valid, bus.in_ready});
    end
    total++;
    if (yv[0] !== 32'd0) begin
      bad++; $display("FAIL rm_y0: got %0d want 0", yv[0]);
    end
    @(negedge clk);
    reset = 1'b0;
    fill_block(200);
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      bus.out_ready = 1'b1;
      #1;
      total++;
      if (bus.out_valid !== 1'b1) begin
        bad++; $display("FAIL rm_valid col%0d: got %b want 1", c, bus.out_valid);
      end
      for (int k = 0; k < 8; k++) begin
        total++;
        if (yv[k] !== 32'(200 + 8 * k + c)) begin
          bad++;
          $display("FAIL rm_y col%0d k%0d: got %0d want %0d", c, k, yv[k], 200 + 8 * k + c);
        end
      end
    end
    @(negedge clk);
    #1;
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL rm_after: got %b want 0", bus.out_valid);
    end
    bus.out_ready = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_fill_drain();
    test_back_pressure();
`ifdef TRANSPOSE_PINGPONG_EN
    test_pingpong();
`endif
    test_full_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
